// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises RX, samples each bit at mid-period, pulses VALID / FRAME_ERR / PAR_ERR.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data bit 7 and the stop bit.
module uart_receiver #(
    parameter int CLKS_PER_BIT = 400,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       VALID,
    output logic       BUSY,
    output logic       FRAME_ERR,
    output logic       PAR_ERR
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rxs;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             idx;
    logic [7:0]             shift;
    logic                   at_full;
    logic                   at_half;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], RX};
        end
    end

    assign rxs     = sync[SYNC_STAGES-1];
    assign at_full = (cnt == FULL_LAST);
    assign at_half = (cnt == HALF_LAST);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`else
    assign PAR_ERR = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            DATA      <= 8'h00;
            VALID     <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PAR_ERR   <= 1'b0;
            par_bad   <= 1'b0;
`endif
        end else begin
            VALID     <= 1'b0;
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PAR_ERR   <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    BUSY <= 1'b0;
                    if (!rxs) begin
                        state <= ST_START;
                        cnt   <= '0;
                        BUSY  <= 1'b1;
                    end
                end

                // A start bit that is high again at mid-period was a glitch.
                ST_START: begin
                    if (at_half) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state <= ST_DATA;
                            idx   <= '0;
                        end else begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DATA: begin
                    if (at_full) begin
                        cnt        <= '0;
                        shift[idx] <= rxs;
                        idx        <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: data bits plus parity bit must XOR to zero.
                ST_PARITY: begin
                    if (at_full) begin
                        cnt     <= '0;
                        par_bad <= rxs ^ (^shift);
                        state   <= ST_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif

                // Leaving at mid stop bit lets the next start edge be caught without a gap.
                ST_STOP: begin
                    if (at_full) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= ST_IDLE;
                            BUSY  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                PAR_ERR <= 1'b1;
                            end else begin
                                DATA  <= shift;
                                VALID <= 1'b1;
                            end
`else
                            DATA  <= shift;
                            VALID <= 1'b1;
`endif
                        end else begin
                            FRAME_ERR <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            PAR_ERR   <= par_bad;
`endif
                            state     <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // Held-low line (break): only re-arm once the line has gone idle again.
                ST_BREAK: begin
                    if (rxs) begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are described as bit lists, expectations queued, a monitor checks every output pulse.
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int  CPB  = 16;
    localparam int  SYNC = 2;
    localparam real TCLK = 10.0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, busy, frame_err, par_err;

    uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .CLK(clk), .RST(rst), .RX(rx),
        .DATA(data), .VALID(valid), .BUSY(busy),
        .FRAME_ERR(frame_err), .PAR_ERR(par_err)
    );

    always #5 clk = ~clk;

    // kind bit0 = frame error expected, bit1 = parity error expected; 0 = good byte.
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: a frame is a list of line levels, each held one (possibly mistimed) bit period.
    task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit par_flip,
                              input int ppm, input int abort_at);
        real  bt;
        logic bits[$];
        exp_t e;
        bit   pbad;
        bt = TCLK * CPB * (1.0 + ppm / 1.0e6);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PAR) bits.push_back((^d) ^ par_flip);
        bits.push_back(stop_b);
        if (abort_at < 0) begin
            pbad   = PAR && par_flip;
            e.kind = {pbad, ~stop_b};
            if (e.kind == 2'b00) last_good = d;
            e.data = last_good;
            expq.push_back(e);
        end
        for (int i = 0; i < bits.size(); i++) begin
            if (i == abort_at) return;
            rx = bits[i];
            #(bt);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        #(TCLK * CPB * n);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (valid || frame_err || par_err) begin
                if (expq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b perr=%0b, expected no pulse at %0t",
                             valid, frame_err, par_err, $time);
                end else begin
                    e = expq.pop_front();
                    check("pulse_flags", {29'd0, valid, par_err, frame_err},
                          {29'd0, (e.kind == 2'b00), e.kind});
                    check("data_at_pulse", {24'd0, data}, {24'd0, e.data});
                    check("busy_at_pulse", {31'd0, busy}, {31'd0, e.kind[0]});
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        bit         stop_b, pf;
        int         ppm;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, data}, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'h0);
        check("rst_busy",  {31'd0, busy}, 32'h0);
        check("rst_ferr",  {31'd0, frame_err}, 32'h0);
        check("rst_perr",  {31'd0, par_err}, 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Single frame at exact rate.
        send_frame(8'hA5, 1'b1, 1'b0, 0, -1);
        idle_bits(1);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 1'b0, 0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, 0, -1);
        send_frame(8'h3C, 1'b1, 1'b0, 0, -1);
        idle_bits(2);

        // Short low glitch must be rejected silently.
        rx = 1'b0;
        #(5 * TCLK);
        rx = 1'b1;
        #(TCLK * CPB * 2);
        check("glitch_busy", {31'd0, busy}, 32'h0);
        send_frame(8'h81, 1'b1, 1'b0, 0, -1);
        idle_bits(1);

        // Stop bit low, line held low: one FRAME_ERR, BUSY until line returns high.
        send_frame(8'h55, 1'b0, 1'b0, 0, -1);
        #(40 * TCLK);
        check("break_busy", {31'd0, busy}, 32'h1);
        check("break_data", {24'd0, data}, {24'd0, last_good});
        rx = 1'b1;
        #(TCLK * CPB);
        check("break_exit_busy", {31'd0, busy}, 32'h0);
        send_frame(8'h12, 1'b1, 1'b0, 0, -1);
        idle_bits(1);

        // Reset in the middle of a frame (at data bit 4).
        send_frame(8'hC3, 1'b1, 1'b0, 0, 5);
        rst = 1'b1;
        #1;
        check("midrst_data",  {24'd0, data}, 32'h0);
        check("midrst_valid", {31'd0, valid}, 32'h0);
        check("midrst_busy",  {31'd0, busy}, 32'h0);
        check("midrst_ferr",  {31'd0, frame_err}, 32'h0);
        check("midrst_perr",  {31'd0, par_err}, 32'h0);
        last_good = 8'h00;
        rx = 1'b1;
        #(4 * TCLK);
        rst = 1'b0;
        #(TCLK * CPB);
        send_frame(8'h7E, 1'b1, 1'b0, 0, -1);
        idle_bits(1);

        // Wrong then right parity bit (parity bit absent in the plain 8N1 build).
        send_frame(8'h0F, 1'b1, 1'b1, 0, -1);
        idle_bits(1);
        send_frame(8'h0F, 1'b1, 1'b0, 0, -1);
        idle_bits(1);

        // Random frames with transmitter clock error up to +/-2%.
        for (int i = 0; i < 30; i++) begin
            d      = 8'($urandom);
            ppm    = int'($urandom_range(0, 40000)) - 20000;
            stop_b = ($urandom_range(0, 7) != 0);
            pf     = ($urandom_range(0, 3) == 0);
            send_frame(d, stop_b, pf, ppm, -1);
            if (!stop_b) begin
                #(TCLK * $urandom_range(1, 40));
                idle_bits(1);
            end
            rx = 1'b1;
            #(TCLK * $urandom_range(0, 24));
        end

        idle_bits(3);
        check("queue_drained", expq.size(), 32'h0);
        check("final_busy", {31'd0, busy}, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #(TCLK * 60000);
        tests++;
        fails++;
        $display("FAIL timeout: got no completion, expected finish before %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule
